instr_queue_decoder: RTL
========================

# instr_queue_decoder

Parametrised instruction queue with field decode, sitting between instruction fetch and the decode/register-read stage of the MIPS datapath. Buffers up to DEPTH fetched words with their PC under a valid/ready handshake, absorbing fetch/decode rate mismatch and stalls. Presents the head entry already split into MIPS fields, with extended immediate, jump target and instruction class. Supports a single-cycle flush for branches and jumps.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- PC_W, 32: PC width; ≥28.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- flush  in  1  discard all entries this edge.
- in_valid  in  1  fetch offers a word.
- in_ready  out  1  queue can accept (count < DEPTH).
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  address of in_instr.
- out_valid  out  1  head entry present (count > 0).
- out_ready  in  1  decode consumes head.
- out_pc  out  PC_W  head PC.
- op, funct  out  6  IR[31:26], IR[5:0].
- rs, rt, rd, shamt  out  5  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
- imm16  out  16  IR[15:0].
- imm_ext  out  32  imm16 zero-extended for op 0x0C/0x0D/0x0E (andi/ori/xori), else sign-extended.
- jtarget  out  PC_W  {(out_pc+4)[PC_W-1:28], IR[25:0], 2'b00}.
- itype  out  2  0=R (op 0x00), 1=J (op 0x02/0x03), 2=I (all others).
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Storage: DEPTH×(32+PC_W) register array, write pointer, read pointer, count; pointers wrap modulo DEPTH.
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- Push writes entry at wptr, wptr+1. Pop advances rptr. count += push − pop.
- Simultaneous push and pop: both occur, count unchanged (possible only when 0<count<DEPTH; when full in_ready=0).
- Push into empty queue: no bypass; entry visible the following cycle.
- flush: pointers and count to 0 at that edge; overrides push and pop in the same cycle (pushed word dropped, pop ignored).
- rst: identical to flush plus output clear; priority rst > flush > push/pop.
- All decoded outputs are combinational from the head entry register. When out_valid=0, every field output, out_pc, imm_ext and jtarget drive 0; itype drives 0.
- Field outputs stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, all data outputs 0.
- Latency in_valid→out_valid: 1 cycle (empty queue).
- Throughput: one push and one pop per cycle sustained.
- in_ready and out_valid depend only on count (registered); no combinational path from out_ready to in_ready or from in_valid to out_valid.
- Cycle after flush: out_valid=0, in_ready=1.
- Wrap-around: entry order preserved across pointer wrap; no bubble at wrap.

## Structure
- Shared package mips_isa_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI), field bit positions, itype encoding constants.
- Sub-module instr_field_split: purely combinational 32-bit word + PC → op/rs/rt/rd/shamt/funct/imm16/imm_ext/jtarget/itype. Queue instantiates one at the head, gated by out_valid.

## Test plan
- Reset then push 0x012A4020 (add $t0,$t1,$t2) pc 0x00400000 → next cycle out_valid=1, op=0, rs=9, rt=10, rd=8, funct=0x20, itype=0.
- Push addi 0x2108FFFF then ori 0x3508FFFF → imm_ext 0xFFFFFFFF, then 0x0000FFFF; itype=2.
- Push j 0x08100004 at pc 0x00400010 → jtarget=0x00400010, itype=1.
- out_ready=0, push DEPTH words → in_ready=0, count=DEPTH; further push ignored; then drain with out_ready=1 → words emerge in order, count reaches 0, across pointer wrap.
- Continuous push+pop for 20 cycles with queue half full → count constant, order preserved.
- Queue holding 3 entries, assert flush with in_valid=1 → next cycle count=0, out_valid=0, pushed word absent; rst mid-stream likewise yields all-zero outputs.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS instruction-set constants shared by the fetch-side queue and its field decoder.
// Opcodes, field bit positions and the coarse instruction class encoding.
package mips_isa_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_W    = 26;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_J = 2'd1,
    ITYPE_I = 2'd2
  } itype_e;

  function automatic itype_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return ITYPE_R;
      OP_J, OP_JAL: return ITYPE_J;
      default:      return ITYPE_I;
    endcase
  endfunction

  // Logical immediates take an unsigned operand; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/instr_queue_decoder_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// The queue uses the slave view; the surrounding pipeline uses the master view.
interface instr_queue_decoder_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 3
);
  import mips_isa_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;

  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [15:0]      imm16;
  logic [31:0]      imm_ext;
  logic [PC_W-1:0]  jtarget;
  itype_e           itype;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, op, funct, rs, rt, rd, shamt,
           imm16, imm_ext, jtarget, itype, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, op, funct, rs, rt, rd, shamt,
           imm16, imm_ext, jtarget, itype, count
  );

endinterface

// File: rtl/instr_field_split.sv
// Purely combinational split of a MIPS word into its fields, extended
// immediate, pseudo-direct jump target and instruction class.
module instr_field_split
  import mips_isa_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  output logic [5:0]         op,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic [31:0]        imm_ext,
  output logic [PC_W-1:0]    jtarget,
  output itype_e             itype
);

  assign op    = instr[OP_LSB    +: 6];
  assign rs    = instr[RS_LSB    +: 5];
  assign rt    = instr[RT_LSB    +: 5];
  assign rd    = instr[RD_LSB    +: 5];
  assign shamt = instr[SHAMT_LSB +: 5];
  assign funct = instr[FUNCT_LSB +: 6];
  assign imm16 = instr[IMM_LSB   +: 16];

  assign imm_ext = is_zero_ext(op) ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  assign itype   = classify(op);

  // Region bits come from the delay-slot PC, so a jump in the last word of a
  // 256 MB region lands in the next one.
  generate
    if (PC_W > 28) begin : g_region
      logic [PC_W-1:0] pc_plus4;
      assign pc_plus4 = pc + PC_W'(4);
      assign jtarget  = {pc_plus4[PC_W-1:28], instr[JIDX_W-1:0], 2'b00};
    end else begin : g_flat
      logic unused_pc;
      assign unused_pc = ^pc;
      assign jtarget   = {instr[JIDX_W-1:0], 2'b00};
    end
  endgenerate

endmodule

// File: rtl/instr_queue_decoder.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of
// {instr, pc} with the head entry presented already decoded.
module instr_queue_decoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  instr_queue_decoder_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;
  logic wr_en;

  // Handshake flags come straight from the registered count, keeping
  // out_ready and in_valid off any combinational path to the other side.
  assign not_full  = (count_q != CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = bus.in_valid  & not_full;
  assign pop       = not_empty     & bus.out_ready;
  assign wr_en     = push & ~bus.flush & ~rst;

  assign bus.in_ready  = not_full;
  assign bus.out_valid = not_empty;
  assign bus.count     = count_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: reset here is synchronous and active-high; the state register
  // uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // observable once count covers it, and the head view is gated below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem_q[wptr_q] <= bus.in_instr;
      pc_mem_q[wptr_q]    <= bus.in_pc;
    end
  end

  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;

  // A zero word at PC 0 decodes to all-zero fields, class R, and a zero jump target.
  assign head_instr = not_empty ? instr_mem_q[rptr_q] : '0;
  assign head_pc    = not_empty ? pc_mem_q[rptr_q]    : '0;
  assign bus.out_pc = head_pc;

  instr_field_split #(
    .PC_W (PC_W)
  ) u_split (
    .instr   (head_instr),
    .pc      (head_pc),
    .op      (bus.op),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .rd      (bus.rd),
    .shamt   (bus.shamt),
    .funct   (bus.funct),
    .imm16   (bus.imm16),
    .imm_ext (bus.imm_ext),
    .jtarget (bus.jtarget),
    .itype   (bus.itype)
  );

endmodule
